// File: rtl/fifo_async_pkg.sv
// Shared helpers for the async FIFO pointer controllers.
// Pointer width, Gray encoding and the default synchroniser depth.
package fifo_async_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    // Callers size-cast the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_async_wptr_ctrl_if.sv
// Write-side request/status bundle between the FIFO user and the write controller.
// The master drives requests and the raw read pointer; the slave (controller) drives RAM port and status.
interface fifo_async_wptr_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    import fifo_async_pkg::*;

    localparam int PW = ptr_w(ADDR_WIDTH);

    logic                  write_in;
    logic [PW-1:0]         rptr_g_in;
    logic [PW-1:0]         af_thresh_in;
    logic                  clr_ovf_in;
    logic [ADDR_WIDTH-1:0] waddr_out;
    logic                  wen_out;
    logic [PW-1:0]         wptr_g_out;
    logic                  full_out;
    logic                  almost_full_out;
    logic [PW-1:0]         wlevel_out;
    logic                  overflow_out;

    modport master (
        output write_in, rptr_g_in, af_thresh_in, clr_ovf_in,
        input  waddr_out, wen_out, wptr_g_out, full_out, almost_full_out,
               wlevel_out, overflow_out
    );

    modport slave (
        input  write_in, rptr_g_in, af_thresh_in, clr_ovf_in,
        output waddr_out, wen_out, wptr_g_out, full_out, almost_full_out,
               wlevel_out, overflow_out
    );

endinterface

// File: rtl/gray2bin.sv
// Gray to binary converter.
// Latency: combinational. Backpressure: none.
module gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] bin_out
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_out = '0;
        for (int i = 0; i < N; i++) begin
            bin_out[i] = ^(gray_in >> i);
        end
    end

endmodule

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into this clock domain.
// Latency: STAGES edges. Backpressure: none, samples every edge.
module sync_ff_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_async_wptr_ctrl.sv
// Async FIFO write-side controller: write pointer, read-pointer sync, full/almost-full/level/overflow.
// Latency: status registered 1 edge after a write, SYNC_STAGES+1 edges after a read. Backpressure: writes dropped while full.
module fifo_async_wptr_ctrl
    import fifo_async_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    clk_in,
    input  logic                    nrst_in,
    fifo_async_wptr_ctrl_if.slave   wif
);

    localparam int            PW    = ptr_w(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0] rptr_g_sync;
    logic [PW-1:0] rptr_b_sync;

    sync_ff_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk_in),
        .rst_n (nrst_in),
        .d_in  (wif.rptr_g_in),
        .q_out (rptr_g_sync)
    );

    gray2bin #(
        .N (PW)
    ) u_rptr_g2b (
        .gray_in (rptr_g_sync),
        .bin_out (rptr_b_sync)
    );

    logic [PW-1:0] wptr_b_q, wptr_b_d;
    logic [PW-1:0] wptr_g_q, wptr_g_d;
    logic [PW-1:0] level_q,  level_d;
    logic          full_q,   full_d;
    logic          af_q,     af_d;
    logic          ovf_q,    ovf_d;
    logic          wen;

    // Status is computed from the post-write pointer so the filling write raises full on its own edge.
    always_comb begin
        wen      = wif.write_in & ~full_q;
        wptr_b_d = wptr_b_q + PW'(wen);
        wptr_g_d = PW'(bin2gray(32'(wptr_b_d)));
        level_d  = wptr_b_d - rptr_b_sync;
        full_d   = (level_d == DEPTH);
        af_d     = (level_d >= wif.af_thresh_in);
        ovf_d    = (wif.write_in & full_q) | (ovf_q & ~wif.clr_ovf_in);
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wptr_b_q <= '0;
            wptr_g_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_b_q <= wptr_b_d;
            wptr_g_q <= wptr_g_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wif.waddr_out       = wptr_b_q[ADDR_WIDTH-1:0];
    assign wif.wen_out         = wen;
    assign wif.wptr_g_out      = wptr_g_q;
    assign wif.full_out        = full_q;
    assign wif.almost_full_out = af_q;
    assign wif.wlevel_out      = level_q;
    assign wif.overflow_out    = ovf_q;

endmodule

// File: tb/tb_fifo_async_wptr_ctrl.sv
// Scoreboard bench for fifo_async_wptr_ctrl with ADDR_WIDTH=3, SYNC_STAGES=2.
module tb_fifo_async_wptr_ctrl;

    typedef struct {
        string      name;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wg;
        logic       full;
        logic [3:0] lvl;
        logic       af;
        logic       ovf;
    } exp_t;

    logic clk;
    logic nrst;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   busy     = 0;
    logic [3:0] wcnt = '0;
    exp_t sb[$];
    exp_t cur;

    fifo_async_wptr_ctrl_if #(.ADDR_WIDTH(3)) wif ();

    fifo_async_wptr_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in  (clk),
        .nrst_in (nrst),
        .wif     (wif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of inputs and queue the hand-computed response.
    task automatic step(input string nm, input bit wr, input logic [3:0] rg,
                        input logic [3:0] thr, input bit clr, input bit e_wen,
                        input bit e_full, input logic [3:0] e_lvl, input bit e_af,
                        input bit e_ovf);
        exp_t e;
        @(negedge clk);
        wif.write_in     = wr;
        wif.rptr_g_in    = rg;
        wif.af_thresh_in = thr;
        wif.clr_ovf_in   = clr;
        e.name  = nm;
        e.wen   = e_wen;
        e.waddr = wcnt[2:0];
        wcnt    = wcnt + 4'(e_wen);
        e.wg    = g4(wcnt);
        e.full  = e_full;
        e.lvl   = e_lvl;
        e.af    = e_af;
        e.ovf   = e_ovf;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(posedge clk);
        end
        if (sb.size() != 0 || busy) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string nm, input logic e_wen);
        chk({nm, ".wen"},   32'(wif.wen_out), 32'(e_wen));
        chk({nm, ".waddr"}, 32'(wif.waddr_out), 32'd0);
        chk({nm, ".wptr_g"}, 32'(wif.wptr_g_out), 32'd0);
        chk({nm, ".full"},  32'(wif.full_out), 32'd0);
        chk({nm, ".af"},    32'(wif.almost_full_out), 32'd0);
        chk({nm, ".lvl"},   32'(wif.wlevel_out), 32'd0);
        chk({nm, ".ovf"},   32'(wif.overflow_out), 32'd0);
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        nrst             = 1'b0;
        wif.write_in     = 1'b0;
        wif.rptr_g_in    = '0;
        wif.clr_ovf_in   = 1'b0;
        wcnt             = '0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Monitor: combinational port just before the edge, registered status just after it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                busy = 1;
                cur  = sb.pop_front();
                chk({cur.name, ".wen"},   32'(wif.wen_out),   32'(cur.wen));
                chk({cur.name, ".waddr"}, 32'(wif.waddr_out), 32'(cur.waddr));
                @(posedge clk);
                #1;
                chk({cur.name, ".wptr_g"}, 32'(wif.wptr_g_out),      32'(cur.wg));
                chk({cur.name, ".full"},   32'(wif.full_out),        32'(cur.full));
                chk({cur.name, ".lvl"},    32'(wif.wlevel_out),      32'(cur.lvl));
                chk({cur.name, ".af"},     32'(wif.almost_full_out), 32'(cur.af));
                chk({cur.name, ".ovf"},    32'(wif.overflow_out),    32'(cur.ovf));
                busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        nrst             = 1'b0;
        wif.write_in     = 1'b0;
        wif.rptr_g_in    = '0;
        wif.af_thresh_in = '0;
        wif.clr_ovf_in   = 1'b0;
        #3;
        chk_all_zero("reset0", 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        // threshold 0: almost-full with an empty FIFO
        step("af_zero", 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0);

        // fill with no reads; almost-full on the 6th write
        for (int j = 0; j < 7; j++)
            step($sformatf("fill%0d", j), 1, 4'd0, 4'd6, 0, 1, 0, 4'(j + 1), (j >= 5), 0);
        step("af_thr8",   0, 4'd0, 4'd8, 0, 0, 0, 4'd7, 0, 0);
        step("fill8",     1, 4'd0, 4'd6, 0, 1, 1, 4'd8, 1, 0);
        step("ovf_w9",    1, 4'd0, 4'd6, 0, 0, 1, 4'd8, 1, 1);
        step("ovf_w10",   1, 4'd0, 4'd6, 0, 0, 1, 4'd8, 1, 1);
        step("set_wins",  1, 4'd0, 4'd6, 1, 0, 1, 4'd8, 1, 1);
        step("clr_only",  0, 4'd0, 4'd6, 1, 0, 1, 4'd8, 1, 0);

        // read pointer Gray(1): full released on the third edge
        step("rel_e1",    0, 4'b0001, 4'd6, 0, 0, 1, 4'd8, 1, 0);
        step("rel_e2",    0, 4'b0001, 4'd6, 0, 0, 1, 4'd8, 1, 0);
        step("rel_e3",    0, 4'b0001, 4'd6, 0, 0, 0, 4'd7, 1, 0);
        step("refill",    1, 4'b0001, 4'd6, 0, 1, 1, 4'd8, 1, 0);
        step("ovf_again", 1, 4'b0001, 4'd6, 0, 0, 1, 4'd8, 1, 1);
        step("wr_rd_same",1, 4'b0011, 4'd6, 0, 0, 1, 4'd8, 1, 1);
        step("pess_e2",   0, 4'b0011, 4'd6, 0, 0, 1, 4'd8, 1, 1);
        step("pess_e3",   0, 4'b0011, 4'd6, 0, 0, 0, 4'd7, 1, 1);
        drain();

        // asynchronous reset between edges with a write pending
        #3;
        nrst             = 1'b0;
        wif.write_in     = 1'b1;
        wif.rptr_g_in    = '0;
        wif.af_thresh_in = 4'd9;
        #1;
        chk_all_zero("async_rst", 1'b1);
        wif.write_in = 1'b0;
        wcnt         = '0;
        @(negedge clk);
        nrst = 1'b1;
        step("post_rst",  1, 4'd0, 4'd9, 0, 1, 0, 4'd1, 0, 0);

        // wrap-around with the read pointer following the write pointer
        do_reset();
        for (int j = 0; j < 40; j++)
            step($sformatf("wrap%0d", j), 1, g4(4'(j)), 4'd9, 0, 1, 0,
                 (j < 2) ? 4'(j + 1) : 4'd3, 0, 0);
        step("wrap_idle", 0, g4(4'd8), 4'd9, 0, 0, 0, 4'd2, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
